// File: rtl/krnl_partialknn_mem_pkg.sv
// Shared state type and sizing helpers for the banked partialKnn local memory.
package krnl_partialknn_mem_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } mem_state_e;

    // Index width with a 1-bit floor so single-bank or single-row builds stay legal.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned bank_shift(input int unsigned num_banks);
        return $clog2(num_banks);
    endfunction

    function automatic int unsigned depth_of(input int unsigned addr_range,
                                             input int unsigned num_banks);
        return addr_range / num_banks;
    endfunction

endpackage

// File: rtl/krnl_partialknn_mem_bank.sv
// One memory bank: Depth x DataWidth, byte-enabled write port, registered read port.
module krnl_partialknn_mem_bank #(
    parameter int DataWidth = 256,
    parameter int Depth     = 512,
    parameter int RowW      = 9
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   we_i,
    input  logic [DataWidth/8-1:0] be_i,
    input  logic [RowW-1:0]        waddr_i,
    input  logic [DataWidth-1:0]   wd_i,
    input  logic                   re_i,
    input  logic [RowW-1:0]        raddr_i,
    output logic [DataWidth-1:0]   rd_o
);
    localparam int NBytes = DataWidth / 8;

    (* ram_style = "ultra" *) logic [DataWidth-1:0] mem_q [Depth];
    logic [DataWidth-1:0] rd_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < NBytes; b++) begin
                if (be_i[b]) mem_q[waddr_i][8*b +: 8] <= wd_i[8*b +: 8];
            end
        end
    end

    // Read-before-write within the bank; the top merges same-address writes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_q <= '0;
        end else if (re_i) begin
            rd_q <= mem_q[raddr_i];
        end
    end

    assign rd_o = rd_q;

endmodule

// File: rtl/krnl_partialknn_local_mem_banked.sv
// Banked 1R1W local memory: clear-after-reset FSM, address decode, write-first merge, read pipeline.
module krnl_partialknn_local_mem_banked
    import krnl_partialknn_mem_pkg::*;
#(
    parameter int DataWidth    = 256,
    parameter int AddressRange = 2048,
    parameter int AddressWidth = 11,
    parameter int NumBanks     = 4,
    parameter int ReadLatency  = 2,
    parameter int ClearOnReset = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [AddressWidth-1:0]   wr_address_i,
    input  logic                      wr_ce_i,
    input  logic [DataWidth/8-1:0]    wr_be_i,
    input  logic [DataWidth-1:0]      wr_d_i,
    input  logic [AddressWidth-1:0]   rd_address_i,
    input  logic                      rd_ce_i,
    output logic [DataWidth-1:0]      rd_q_o,
    output logic                      rd_valid_o,
    output logic                      init_done_o
);
    localparam int NBytes = DataWidth / 8;
    localparam int BankSh = bank_shift(NumBanks);
    localparam int BankW  = idx_width(NumBanks);
    localparam int Depth  = depth_of(AddressRange, NumBanks);
    localparam int RowW   = idx_width(Depth);
    localparam logic [AddressWidth:0] RangeEnd = (AddressWidth+1)'(AddressRange);
    localparam logic [RowW-1:0]       LastRow  = RowW'(Depth - 1);

    mem_state_e      state_q, state_d;
    logic [RowW-1:0] clr_cnt_q, clr_cnt_d;
    logic            init_done_q, init_done_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= (ClearOnReset != 0) ? ST_CLEAR : ST_RUN;
            clr_cnt_q   <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            init_done_q <= init_done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        init_done_d = init_done_q;
        case (state_q)
            ST_CLEAR: begin
                clr_cnt_d = clr_cnt_q + RowW'(1);
                if (clr_cnt_q == LastRow) begin
                    state_d     = ST_RUN;
                    clr_cnt_d   = '0;
                    init_done_d = 1'b1;
                end
            end
            default: init_done_d = 1'b1;
        endcase
    end

    logic                 clearing, wr_in, rd_in, wr_acc, rd_acc;
    logic [BankW-1:0]     wr_bank, rd_bank, rd_bank_q;
    logic [RowW-1:0]      wr_row, rd_row, bank_waddr;
    logic [NBytes-1:0]    bank_be;
    logic [DataWidth-1:0] bank_wd;

    assign clearing   = (state_q == ST_CLEAR);
    assign wr_in      = {1'b0, wr_address_i} < RangeEnd;
    assign rd_in      = {1'b0, rd_address_i} < RangeEnd;
    assign wr_acc     = init_done_q && wr_ce_i && wr_in;
    assign rd_acc     = init_done_q && rd_ce_i;
    assign wr_bank    = BankW'(wr_address_i & AddressWidth'(NumBanks - 1));
    assign rd_bank    = BankW'(rd_address_i & AddressWidth'(NumBanks - 1));
    assign wr_row     = RowW'(wr_address_i >> BankSh);
    assign rd_row     = RowW'(rd_address_i >> BankSh);
    assign bank_waddr = clearing ? clr_cnt_q : wr_row;
    assign bank_be    = clearing ? '1 : wr_be_i;
    assign bank_wd    = clearing ? '0 : wr_d_i;

    logic [DataWidth-1:0] bank_rd [NumBanks];

    for (genvar k = 0; k < NumBanks; k++) begin : g_bank
        logic we_k, re_k;
        assign we_k = clearing || (wr_acc && (wr_bank == BankW'(k)));
        assign re_k = rd_acc && rd_in && (rd_bank == BankW'(k));

        krnl_partialknn_mem_bank #(
            .DataWidth (DataWidth),
            .Depth     (Depth),
            .RowW      (RowW)
        ) u_bank (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .we_i    (we_k),
            .be_i    (bank_be),
            .waddr_i (bank_waddr),
            .wd_i    (bank_wd),
            .re_i    (re_k),
            .raddr_i (rd_row),
            .rd_o    (bank_rd[k])
        );
    end

    // Stage-1 side info travels beside the bank output register; all of it holds between reads.
    logic [NBytes-1:0]    fwd_be_q;
    logic [DataWidth-1:0] fwd_d_q;
    logic                 oor_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_bank_q <= '0;
            oor_q     <= 1'b0;
            fwd_be_q  <= '0;
            fwd_d_q   <= '0;
        end else if (rd_acc) begin
            rd_bank_q <= rd_bank;
            oor_q     <= !rd_in;
            fwd_be_q  <= (wr_acc && (wr_address_i == rd_address_i)) ? wr_be_i : '0;
            fwd_d_q   <= wr_d_i;
        end
    end

    logic [DataWidth-1:0] s1_data;

    always_comb begin
        s1_data = '0;
        if (!oor_q) begin
            for (int b = 0; b < NBytes; b++) begin
                s1_data[8*b +: 8] = fwd_be_q[b] ? fwd_d_q[8*b +: 8] : bank_rd[rd_bank_q][8*b +: 8];
            end
        end
    end

    logic [ReadLatency-1:0] vld_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q <= '0;
        end else begin
            vld_q <= ReadLatency'({vld_q, rd_acc});
        end
    end

    if (ReadLatency == 1) begin : g_lat1
        assign rd_q_o = s1_data;
    end else begin : g_latn
        logic [DataWidth-1:0] pipe_q [ReadLatency-1];

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int i = 0; i < ReadLatency - 1; i++) pipe_q[i] <= '0;
            end else begin
                if (vld_q[0]) pipe_q[0] <= s1_data;
                for (int i = 1; i < ReadLatency - 1; i++) begin
                    if (vld_q[i]) pipe_q[i] <= pipe_q[i-1];
                end
            end
        end

        assign rd_q_o = pipe_q[ReadLatency-2];
    end

    assign rd_valid_o  = vld_q[ReadLatency-1];
    assign init_done_o = init_done_q;

endmodule

// File: tb/tb_krnl_partialknn_local_mem_banked.sv
// Bench for krnl_partialknn_local_mem_banked: vector table plus scoreboard-checked read stream.
module tb_krnl_partialknn_local_mem_banked;
    localparam int DW    = 256;
    localparam int AW    = 12;
    localparam int NB    = 4;
    localparam int RL    = 2;
    localparam int DEPTH = 512;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] wr_address = '0;
    logic          wr_ce = 1'b0;
    logic [DW/8-1:0] wr_be = '0;
    logic [DW-1:0] wr_d = '0;
    logic [AW-1:0] rd_address = '0;
    logic          rd_ce = 1'b0;
    logic [DW-1:0] rd_q;
    logic          rd_valid;
    logic          init_done;

    krnl_partialknn_local_mem_banked #(
        .DataWidth    (DW),
        .AddressRange (2048),
        .AddressWidth (AW),
        .NumBanks     (NB),
        .ReadLatency  (RL),
        .ClearOnReset (1)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .wr_address_i (wr_address),
        .wr_ce_i      (wr_ce),
        .wr_be_i      (wr_be),
        .wr_d_i       (wr_d),
        .rd_address_i (rd_address),
        .rd_ce_i      (rd_ce),
        .rd_q_o       (rd_q),
        .rd_valid_o   (rd_valid),
        .init_done_o  (init_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        bit            wce;
        logic [AW-1:0] wa;
        logic [31:0]   be;
        logic [DW-1:0] wd;
        bit            rce;
        logic [AW-1:0] ra;
        logic [DW-1:0] exp;
    } vec_t;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
        int            tag;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];
    int   checks = 0;
    int   failures = 0;
    int   tag_n = 0;

    function automatic logic [DW-1:0] rep(input logic [7:0] b);
        return {32{b}};
    endfunction

    task automatic chk_d(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s act=%h req=%h", nm, act, req);
        end
    endtask

    task automatic chk_i(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s act=%0d req=%0d", nm, act, req);
        end
    endtask

    task automatic add(input bit wce, input logic [AW-1:0] wa, input logic [31:0] be,
                       input logic [DW-1:0] wd, input bit rce, input logic [AW-1:0] ra,
                       input logic [DW-1:0] exp);
        vec_t v;
        v.wce = wce; v.wa = wa; v.be = be; v.wd = wd;
        v.rce = rce; v.ra = ra; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        sb_t e;
        @(negedge clk);
        wr_ce = v.wce; wr_address = v.wa; wr_be = v.be; wr_d = v.wd;
        rd_ce = v.rce; rd_address = v.ra;
        if (v.rce) begin
            e.data = v.exp; e.due = cyc + RL; e.tag = tag_n;
            sb.push_back(e);
            tag_n++;
        end
    endtask

    task automatic idle();
        @(negedge clk);
        wr_ce = 1'b0; rd_ce = 1'b0; wr_be = '0;
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && sb.size() > 0; k++) @(negedge clk);
        chk_i("drain_pending", sb.size(), 0);
    endtask

    task automatic wait_init(input string nm);
        int n;
        n = 0;
        while (!init_done && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 500) rd_ce = 1'b0;
        end
        chk_i(nm, n, DEPTH);
    endtask

    always @(negedge clk) begin : mon
        sb_t e;
        if (rd_valid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL stray_rd_valid act=1 req=0 cyc=%0d", cyc);
            end else begin
                e = sb.pop_front();
                chk_d($sformatf("rd_q_tag%0d", e.tag), rd_q, e.data);
                chk_i($sformatf("rd_lat_tag%0d", e.tag), cyc, e.due);
            end
        end
    end

    initial begin
        logic [DW-1:0] mix9, top7;
        mix9 = {{31{8'h11}}, 8'hFF};
        top7 = {{4{8'h12}}, {28{8'h00}}};

        add(0, 12'h000, 32'h0, '0, 1, 12'h7FF, '0);
        add(1, 12'd5, '1, rep(8'hA5), 0, 12'h000, '0);
        add(0, 12'h000, 32'h0, '0, 1, 12'd5, rep(8'hA5));
        add(1, 12'd9, '1, rep(8'h11), 0, 12'h000, '0);
        add(1, 12'd9, 32'h1, rep(8'hFF), 1, 12'd9, mix9);
        add(1, 12'd2048, '1, rep(8'h77), 0, 12'h000, '0);
        add(0, 12'h000, 32'h0, '0, 1, 12'd2048, '0);
        add(0, 12'h000, 32'h0, '0, 1, 12'd0, '0);
        add(1, 12'd3, 32'h0, rep(8'hEE), 1, 12'd3, '0);
        add(1, 12'd6, '1, rep(8'h66), 1, 12'd6, rep(8'h66));
        add(0, 12'h000, 32'h0, '0, 1, 12'd6, rep(8'h66));
        add(0, 12'h000, 32'h0, '0, 1, 12'd9, mix9);
        add(1, 12'h7FF, '1, rep(8'hC3), 0, 12'h000, '0);
        add(0, 12'h000, 32'h0, '0, 1, 12'h7FF, rep(8'hC3));
        add(1, 12'd7, 32'hF000_0000, rep(8'h12), 1, 12'd7, top7);
        for (int i = 0; i < 8; i++)
            add(1, AW'(i), '1, rep(8'(8'h30 + i)), 0, 12'h000, '0);
        for (int i = 0; i < 8; i++)
            add(1, AW'(8 + i), '1, rep(8'(8'h40 + i)), 1, AW'(i), rep(8'(8'h30 + i)));
        for (int i = 0; i < 8; i++)
            add(0, 12'h000, 32'h0, '0, 1, AW'(8 + i), rep(8'(8'h40 + i)));

        repeat (3) @(posedge clk);
        #1;
        chk_i("reset_rd_valid", int'(rd_valid), 0);
        chk_i("reset_init_done", int'(init_done), 0);
        chk_d("reset_rd_q", rd_q, '0);

        @(negedge clk);
        rst_n = 1'b1;
        rd_ce = 1'b1;
        rd_address = '0;
        wait_init("init_cycles");

        foreach (vecs[i]) drive(vecs[i]);
        idle();
        drain();
        repeat (3) idle();
        chk_i("hold_rd_valid", int'(rd_valid), 0);
        chk_d("hold_rd_q", rd_q, rep(8'h47));

        @(negedge clk);
        rd_ce = 1'b1; rd_address = 12'd0;
        @(negedge clk);
        rd_address = 12'd1;
        @(posedge clk);
        #1;
        rd_ce = 1'b0;
        chk_i("inflight_rd_valid", int'(rd_valid), 1);
        rst_n = 1'b0;
        #1;
        chk_i("rst_drop_rd_valid", int'(rd_valid), 0);
        chk_i("rst_drop_init_done", int'(init_done), 0);
        chk_d("rst_drop_rd_q", rd_q, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_init("reinit_cycles");

        begin
            vec_t v;
            v.wce = 0; v.wa = '0; v.be = '0; v.wd = '0; v.rce = 1;
            v.ra = 12'd0;  v.exp = '0; drive(v);
            v.ra = 12'd13; v.exp = '0; drive(v);
        end
        idle();
        drain();
        repeat (4) idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
